// File: rtl/winner_finder_if.sv
// -----------------------------------------------------------------------------
// Module     : winner_finder_if
// Description: Request/result bundle for the four-candidate vote scanner.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface winner_finder_if;
  logic       start;
  logic [3:0] count0;
  logic [3:0] count1;
  logic [3:0] count2;
  logic [3:0] count3;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic [3:0] max_votes;
  logic       tie;

  modport master (
    output start, count0, count1, count2, count3,
    input  busy, done, winner, max_votes, tie
  );

  modport slave (
    input  start, count0, count1, count2, count3,
    output busy, done, winner, max_votes, tie
  );
endinterface

`default_nettype wire

// File: rtl/winner_finder.sv
// -----------------------------------------------------------------------------
// Module     : winner_finder
// Description: Snapshots four vote counts and scans them one per cycle to find
//              the highest count, its lowest index, and whether it is tied.
// Revision   : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module winner_finder (
  input  wire logic       clk,
  input  wire logic       rst_n,
  winner_finder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_snap [4];
  logic [1:0] r_idx;
  logic [1:0] r_winner;
  logic [3:0] r_max_votes;
  logic       r_tie;
  logic       r_busy;
  logic       r_done;

  logic       w_load;
  logic [3:0] w_snap_cur;
  logic       w_gt;
  logic       w_eq;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only looked at while idle
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = SCAN;
          w_load       = 1'b1;
        end
      end
      SCAN: begin
        if (r_idx == 2'd3) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_snap_cur = r_snap[r_idx];
    w_gt       = (w_snap_cur >  r_max_votes);
    w_eq       = (w_snap_cur == r_max_votes);
  end

  // Datapath and registered outputs; busy/done are decoded from the next state
  // so they line up with the state they describe without a combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 4'd0;
      end
      r_idx       <= 2'd0;
      r_winner    <= 2'd0;
      r_max_votes <= 4'd0;
      r_tie       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_state_next != IDLE);
      r_done <= (w_state_next == DONE);
      if (w_load) begin
        r_snap[0]   <= bus.count0;
        r_snap[1]   <= bus.count1;
        r_snap[2]   <= bus.count2;
        r_snap[3]   <= bus.count3;
        r_max_votes <= bus.count0;
        r_winner    <= 2'd0;
        r_tie       <= 1'b0;
        r_idx       <= 2'd1;
      end else if (r_state == SCAN) begin
        // Strictly-greater replaces, so the lowest index keeps a tie
        if (w_gt) begin
          r_max_votes <= w_snap_cur;
          r_winner    <= r_idx;
          r_tie       <= 1'b0;
        end else if (w_eq) begin
          r_tie <= 1'b1;
        end
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.winner    = r_winner;
  assign bus.max_votes = r_max_votes;
  assign bus.tie       = r_tie;

endmodule

`default_nettype wire

// File: doc/winner_finder.md
WINNER_FINDER -- requirements
Module: winner_finder

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL expose port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL expose port: start  input  1  request a scan; sampled only in IDLE.
REQ-005 SHALL expose port: count0  input  4  vote count, candidate 0 (unsigned).
REQ-006 SHALL expose port: count1  input  4  vote count, candidate 1 (unsigned).
REQ-007 SHALL expose port: count2  input  4  vote count, candidate 2 (unsigned).
REQ-008 SHALL expose port: count3  input  4  vote count, candidate 3 (unsigned).
REQ-009 SHALL expose port: busy  output  1  high while a scan is in progress (SCAN or DONE state).
REQ-010 SHALL expose port: done  output  1  one-cycle pulse; results valid from this cycle.
REQ-011 SHALL expose port: winner  output  2  index of the highest-count candidate.
REQ-012 SHALL expose port: max_votes  output  4  highest count found.
REQ-013 SHALL expose port: tie  output  1  high if at least one other candidate equals max_votes.
REQ-014 SHALL use no parameters; the widths above are fixed.

Function
REQ-015 SHALL implement an FSM with states IDLE, SCAN and DONE, held in registered state.
REQ-016 SHALL, in IDLE with start=1 at edge T0:
- snapshot count0..count3 into internal registers;
- load max_votes=count0, winner=0, tie=0, idx=1;
- go to SCAN.
REQ-017 SHALL ignore later changes on count0..count3 until the next accepted start.
REQ-018 SHALL, in SCAN, compare one snapshot value per cycle, snap[idx] versus max_votes, as a 4-bit unsigned magnitude compare.
REQ-019 SHALL, when snap[idx] > max_votes, set max_votes=snap[idx], winner=idx and tie=0.
REQ-020 SHALL, when snap[idx] == max_votes, set tie=1 and leave winner unchanged, so the lowest index wins a tie.
REQ-021 SHALL, when snap[idx] < max_votes, leave max_votes, winner and tie unchanged.
REQ-022 SHALL increment idx after each compare; after the idx=3 compare (edge T3) go to DONE.
REQ-023 SHALL, in DONE (cycle after edge T3), drive done=1 for exactly one cycle, then return to IDLE at edge T4.
- Start-to-done latency is fixed: 4 clock edges.
REQ-024 SHALL drive busy=1 in SCAN and DONE and busy=0 in IDLE.
REQ-025 SHALL ignore start while busy=1; the request is not queued.
REQ-026 SHALL accept a start asserted in the same cycle that busy falls to 0 (IDLE) at the next edge, giving back-to-back scans at 5-cycle spacing.
REQ-027 SHALL hold winner, max_votes and tie stable from done until the next accepted start reloads them.
REQ-028 SHALL treat all-equal inputs, including all zero, as winner=0, max_votes=the common value, tie=1.
REQ-029 SHALL register all outputs, with no combinational path from an input to an output.

Reset
REQ-030 SHALL, on rst_n=0 and regardless of clk, force state=IDLE, busy=0, done=0, winner=0, max_votes=0, tie=0, idx=0 and snapshot registers=0.
REQ-031 SHALL, on reset during SCAN or DONE, abort the scan with no done pulse, and leave start ignored until rst_n=1 is sampled.
REQ-032 SHALL leave reset deassertion free of output glitches; the first accepted start is on the first rising edge with rst_n=1.

Verification
REQ-033 SHALL cover: counts (3,9,5,2), pulse start -> done 4 edges later, winner=1, max_votes=9, tie=0, busy high 4 cycles.
REQ-034 SHALL cover: counts (7,4,7,7) -> winner=0, max_votes=7, tie=1.
REQ-035 SHALL cover: counts (2,6,6,15) -> winner=3, max_votes=15, tie=0 (a later greater value clears an earlier tie).
REQ-036 SHALL cover: counts all 0 -> winner=0, max_votes=0, tie=1; counts all 15 -> winner=0, max_votes=15, tie=1.
REQ-037 SHALL cover: change counts to (0,0,0,15) one cycle after start, and pulse start again during SCAN -> result uses the original snapshot, with a single done and no second scan.
REQ-038 SHALL cover: rst_n=0 asynchronously mid-SCAN -> all outputs 0 immediately, no done; after release, a new start with (1,2,3,4) -> winner=3, max_votes=4.
